dvp_frame_tx: RTL and testbench

// - Camera-side DVP (OV-style) transmitter: emits pclk/vsync/href/data[7:0] RGB565 frames from an internal pattern generator.
// - Drives the DVP inputs of the ping-pong buffer / JPEG pipeline in sim and on-board loopback; replaces the physical sensor.
// - Deterministic patterns so JPEG output and buffer fill can be checked without a camera.

---
 rtl/dvp_frame_tx.sv | 204 ++++++++++++++++++++
 tb/tb_dvp_frame_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dvp_frame_tx.sv
// DVP (OV-style) camera-side transmitter: pclk = clk/2, RGB565 frames from an internal pattern generator.
// Optional build macro DVP_TX_CONTINUOUS_EN: frames repeat back-to-back after the first start.
module dvp_frame_tx #(
    parameter int unsigned WIDTH       = 1280,
    parameter int unsigned HEIGHT      = 720,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned VBP_LINES   = 17,
    parameter int unsigned VFP_LINES   = 10,
    parameter int unsigned HBLANK      = 144
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] pattern_sel,
    output logic       busy,
    output logic       frame_done,
    output logic       pclk,
    output logic       vsync,
    output logic       href,
    output logic [7:0] data
);
    localparam int unsigned LINE_LEN  = 2 * WIDTH + HBLANK;
    localparam int unsigned COL_W     = $clog2(LINE_LEN);
    localparam int unsigned MAX_AB    = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
    localparam int unsigned MAX_CD    = (HEIGHT > VFP_LINES) ? HEIGHT : VFP_LINES;
    localparam int unsigned MAX_LINES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned LN_W      = $clog2(MAX_LINES + 1);
    localparam int unsigned BAR_W     = WIDTH / 8;
    localparam int unsigned BAR_PX_W  = $clog2(BAR_W + 1);

    localparam logic [COL_W-1:0]    COL_LAST = COL_W'(LINE_LEN - 1);
    localparam logic [COL_W-1:0]    ACT_COLS = COL_W'(2 * WIDTH);
    localparam logic [BAR_PX_W-1:0] BAR_LAST = BAR_PX_W'(BAR_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LN_W-1:0]     line_q, line_d, phase_last;
    logic                pend_q, pend_d;
    logic [1:0]          pat_q, pat_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    // Only the low five bits of the frame counter ever reach the ramp pattern.
    logic [4:0]          frame_cnt_q, frame_cnt_d;
    logic                pclk_q;
    logic                vsync_q, vsync_d;
    logic                href_q, href_d;
    logic [7:0]          data_q, data_d;
    logic [BAR_PX_W-1:0] bar_px_q, bar_px_d;
    logic [3:0]          bar_idx_q, bar_idx_d;
    logic [7:0]          x_b, y_b;
    logic [15:0]         pix;
    logic                tick;

    assign tick = pclk_q;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        line_d      = line_q;
        pend_d      = pend_q;
        pat_d       = pat_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        vsync_d     = vsync_q;
        href_d      = href_q;
        data_d      = data_q;
        bar_px_d    = bar_px_q;
        bar_idx_d   = bar_idx_q;
        x_b         = 8'h00;
        y_b         = 8'h00;
        pix         = 16'h0000;

        case (state_q)
            S_VSYNC:  phase_last = LN_W'(VSYNC_LINES - 1);
            S_VBP:    phase_last = LN_W'(VBP_LINES - 1);
            S_ACTIVE: phase_last = LN_W'(HEIGHT - 1);
            default:  phase_last = LN_W'(VFP_LINES - 1);
        endcase

        if (state_q == S_IDLE) begin
            if (start) pend_d = 1'b1;
            if (tick && (pend_q || start)) begin
                state_d = S_VSYNC;
                col_d   = '0;
                line_d  = '0;
                pat_d   = pattern_sel;
                busy_d  = 1'b1;
                pend_d  = 1'b0;
            end
        end else if (tick) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (line_q == phase_last) begin
                    line_d = '0;
                    case (state_q)
                        S_VSYNC:  state_d = S_VBP;
                        S_VBP:    state_d = S_ACTIVE;
                        S_ACTIVE: state_d = S_VFP;
                        default: begin
                            done_d      = 1'b1;
                            frame_cnt_d = frame_cnt_q + 1'b1;
`ifdef DVP_TX_CONTINUOUS_EN
                            state_d     = S_VSYNC;
                            pat_d       = pattern_sel;
`else
                            state_d     = S_IDLE;
                            busy_d      = 1'b0;
`endif
                        end
                    endcase
                end else begin
                    line_d = line_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // Outputs are recomputed only on ticks so they hold across the next pclk rising edge.
        if (tick) begin
            if (col_d == '0) begin
                bar_px_d  = '0;
                bar_idx_d = '0;
            end else if (!col_d[0]) begin
                if (bar_px_q == BAR_LAST) begin
                    bar_px_d  = '0;
                    bar_idx_d = (bar_idx_q == 4'd8) ? 4'd8 : bar_idx_q + 4'd1;
                end else begin
                    bar_px_d  = bar_px_q + 1'b1;
                end
            end

            x_b = 8'(col_d >> 1);
            y_b = 8'(line_d);
            case (pat_q)
                2'd0: begin
                    case (bar_idx_d)
                        4'd0:    pix = 16'hFFFF;
                        4'd1:    pix = 16'hFFE0;
                        4'd2:    pix = 16'h07FF;
                        4'd3:    pix = 16'h07E0;
                        4'd4:    pix = 16'hF81F;
                        4'd5:    pix = 16'hF800;
                        4'd6:    pix = 16'h001F;
                        default: pix = 16'h0000;
                    endcase
                end
                2'd1:    pix = {x_b[4:0], y_b[5:0], frame_cnt_q};
                2'd2:    pix = (x_b[3] ^ y_b[3]) ? 16'hFFFF : 16'h0000;
                default: pix = {y_b, x_b};
            endcase

            vsync_d = (state_d == S_VSYNC);
            href_d  = (state_d == S_ACTIVE) && (col_d < ACT_COLS);
            data_d  = href_d ? (col_d[0] ? pix[7:0] : pix[15:8]) : 8'h00;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            line_q      <= '0;
            pend_q      <= 1'b0;
            pat_q       <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            pclk_q      <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'h00;
            bar_px_q    <= '0;
            bar_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            line_q      <= line_d;
            pend_q      <= pend_d;
            pat_q       <= pat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            pclk_q      <= ~pclk_q;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
            bar_px_q    <= bar_px_d;
            bar_idx_q   <= bar_idx_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign pclk       = pclk_q;
    assign vsync      = vsync_q;
    assign href       = href_q;
    assign data       = data_q;
endmodule

// File: tb/tb_dvp_frame_tx.sv
// Directed bench for dvp_frame_tx on a 16x4 frame (1 vsync, 1 VBP, 1 VFP line, HBLANK 4).
module tb_dvp_frame_tx;
    localparam int W      = 16;
    localparam int H      = 4;
    localparam int NBYTES = 2 * W * H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] pattern_sel;
    logic       busy, frame_done, pclk, vsync, href;
    logic [7:0] data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] bytes_q[$];
    int vs_pclks, bursts, stable_err, done_seen, done_after, busy_at_done;
    int vs_first, href_first, done_c;

    dvp_frame_tx #(
        .WIDTH(W), .HEIGHT(H), .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1), .HBLANK(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern_sel(pattern_sel),
        .busy(busy), .frame_done(frame_done), .pclk(pclk), .vsync(vsync),
        .href(href), .data(data)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [1:0] pat, input int y, input int col,
                                            input int fcnt);
        logic [15:0] px;
        logic [7:0]  xv, yv;
        logic [4:0]  fv;
        int          x, bar;
        x   = col / 2;
        xv  = 8'(x);
        yv  = 8'(y);
        fv  = 5'(fcnt);
        bar = x / (W / 8);
        case (pat)
            2'd0: begin
                case (bar)
                    0:       px = 16'hFFFF;
                    1:       px = 16'hFFE0;
                    2:       px = 16'h07FF;
                    3:       px = 16'h07E0;
                    4:       px = 16'hF81F;
                    5:       px = 16'hF800;
                    6:       px = 16'h001F;
                    default: px = 16'h0000;
                endcase
            end
            2'd1:    px = {xv[4:0], yv[5:0], fv};
            2'd2:    px = (((x / 8) % 2) != ((y / 8) % 2)) ? 16'hFFFF : 16'h0000;
            default: px = {yv, xv};
        endcase
        return (col % 2 == 1) ? px[7:0] : px[15:8];
    endfunction

    // Records one frame sample by sample on falling clk edges; optionally issues the start pulse
    // and a mid-frame start/pattern_sel disturbance at sample poke_at.
    task automatic capture(input bit do_start, input logic [1:0] pat, input int poke_at);
        logic       p_pclk, p_vs, p_href;
        logic [7:0] p_data;
        bytes_q.delete();
        vs_pclks = 0; bursts = 0; stable_err = 0; done_seen = 0; done_after = -1;
        busy_at_done = -1; vs_first = -1; href_first = -1; done_c = -1;
        p_pclk = pclk; p_vs = vsync; p_href = href; p_data = data;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (vs_first < 0 && vsync) vs_first = c;
            if (href_first < 0 && href) href_first = c;
            if (pclk && !p_pclk) begin
                if (vsync) vs_pclks++;
                if (href) bytes_q.push_back(data);
                if (data !== p_data || vsync !== p_vs || href !== p_href) stable_err++;
            end
            if (href && !p_href) bursts++;
            p_pclk = pclk; p_vs = vsync; p_href = href; p_data = data;
            if (do_start && c == 0) begin start = 1'b1; pattern_sel = pat; end
            if (do_start && c == 1) start = 1'b0;
            if (poke_at >= 0 && c == poke_at) begin start = 1'b1; pattern_sel = 2'd2; end
            if (poke_at >= 0 && c == poke_at + 4) start = 1'b0;
            if (frame_done) begin
                done_seen    = 1;
                done_c       = c;
                busy_at_done = int'(busy);
                @(negedge clk);
                done_after   = int'(frame_done);
                break;
            end
        end
    endtask

    task automatic check_frame(input logic [1:0] pat, input int fcnt, input bit full,
                               input int exp_busy);
        check("frame_done_seen", done_seen, 1);
        check("frame_done_width", done_after, 0);
        check("busy_at_done", busy_at_done, exp_busy);
        if (full) begin
            check("vsync_latency_le3", (vs_first >= 1 && vs_first <= 2), 1);
            check("vsync_pclks", vs_pclks, 36);
            check("first_href_clks", href_first - vs_first, 144);
            check("frame_len_clks", done_c - vs_first, 504);
        end
        check("href_bursts", bursts, 4);
        check("byte_count", bytes_q.size(), NBYTES);
        check("stable_at_pclk_rise", stable_err, 0);
        for (int i = 0; i < bytes_q.size() && i < NBYTES; i++)
            check($sformatf("byte_y%0d_c%0d", i / (2 * W), i % (2 * W)), bytes_q[i],
                  exp_byte(pat, i / (2 * W), i % (2 * W), fcnt));
    endtask

    initial begin
        int   idle_err, b;
        logic p, ph;
        rst_n = 1'b0; start = 1'b0; pattern_sel = 2'd0;

        repeat (3) @(negedge clk);
        check("rst_pclk", pclk, 0);
        check("rst_vsync", vsync, 0);
        check("rst_href", href, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_data", data, 0);

        rst_n    = 1'b1;
        p        = pclk;
        idle_err = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("pclk_toggle", pclk, !p);
            p = pclk;
            if (vsync || href || busy || frame_done || data != 8'h00) idle_err++;
        end
        check("idle_quiet", idle_err, 0);

`ifdef DVP_TX_CONTINUOUS_EN
        capture(1'b1, 2'd1, -1);
        check_frame(2'd1, 0, 1'b1, 1);
        capture(1'b0, 2'd1, -1);
        check_frame(2'd1, 1, 1'b0, 1);
        capture(1'b0, 2'd1, -1);
        check_frame(2'd1, 2, 1'b0, 1);
`else
        capture(1'b1, 2'd3, -1);
        check_frame(2'd3, 0, 1'b1, 0);

        capture(1'b1, 2'd0, 200);
        check_frame(2'd0, 0, 1'b1, 0);
        idle_err = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vsync || busy || href) idle_err++;
        end
        check("no_extra_frame", idle_err, 0);

        @(negedge clk);
        start = 1'b1; pattern_sel = 2'd2;
        @(negedge clk);
        start = 1'b0;
        b  = 0;
        ph = href;
        for (int c = 0; c < 600 && b < 3; c++) begin
            @(negedge clk);
            if (href && !ph) b++;
            ph = href;
        end
        check("reached_active_line2", b, 3);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pclk", pclk, 0);
        check("async_rst_vsync", vsync, 0);
        check("async_rst_href", href, 0);
        check("async_rst_data", data, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", frame_done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        capture(1'b1, 2'd2, -1);
        check_frame(2'd2, 0, 1'b1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
